// File: rtl/timer_pkg.sv
// Shared timer definitions: default widths and the per-channel capture state encoding.
package timer_pkg;

    localparam int TIMER_CNT_WIDTH = 32;
    localparam int TIMER_CH_NUM    = 8;

    typedef enum logic [1:0] {
        CAP_IDLE     = 2'd0,
        CAP_CAPTURED = 2'd1,
        CAP_OVERRUN  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/timer_capture_channel.sv
// One input-capture channel: capture register plus pending/overrun state.
// With TIMER_CAPTURE_HOLD_FIRST_EN defined, a pending capture is not overwritten.
module timer_capture_channel
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = TIMER_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 edge_i,
    input  logic                 clr_i,
    input  logic [CNT_WIDTH-1:0] tc_value_i,
    output logic [CNT_WIDTH-1:0] cap_value_o,
    output logic                 flag_o,
    output logic                 ovf_o,
    output logic                 flag_next_o
);

    cap_state_t           state_q;
    logic [CNT_WIDTH-1:0] cap_q;
    logic                 wr_en_s;

    // Decide whether this cycle's edge loads the capture register.
    always_comb begin
        wr_en_s = 1'b0;
`ifdef TIMER_CAPTURE_HOLD_FIRST_EN
        // A clear in the same cycle consumes the held value, so the new edge is accepted.
        wr_en_s = edge_i & ((state_q == CAP_IDLE) | clr_i);
`else
        wr_en_s = edge_i;
`endif
    end

    // Capture register and per-channel state machine; an edge always beats a clear.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= CAP_IDLE;
            cap_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            if (wr_en_s) begin
                cap_q <= tc_value_i;
            end else begin
                cap_q <= cap_q;
            end
            case (state_q)
                CAP_IDLE: begin
                    if (edge_i) begin
                        state_q <= CAP_CAPTURED;
                    end else begin
                        state_q <= CAP_IDLE;
                    end
                end
                CAP_CAPTURED, CAP_OVERRUN: begin
                    if (edge_i && clr_i) begin
                        state_q <= CAP_CAPTURED;
                    end else if (edge_i) begin
                        state_q <= CAP_OVERRUN;
                    end else if (clr_i) begin
                        state_q <= CAP_IDLE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: state_q <= CAP_IDLE;
            endcase
        end
    end

    assign cap_value_o = cap_q;
    assign flag_o      = (state_q != CAP_IDLE);
    assign ovf_o       = (state_q == CAP_OVERRUN);
    assign flag_next_o = edge_i | (flag_o & ~clr_i);

endmodule

// File: rtl/timer_input_capture.sv
// Timer input-capture block: per-channel capture, read-to-clear access and registered irq.
// Optional macro TIMER_CAPTURE_HOLD_FIRST_EN keeps the first pending capture per channel.
module timer_input_capture
    import timer_pkg::*;
#(
    parameter int WIDTH     = TIMER_CH_NUM,
    parameter int CNT_WIDTH = TIMER_CNT_WIDTH,
    parameter int SEL_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [WIDTH-1:0]     edge_detected,
    input  logic [CNT_WIDTH-1:0] tc_value,
    input  logic [WIDTH-1:0]     cap_ie,
    input  logic                 rd_en,
    input  logic [SEL_WIDTH-1:0] rd_sel,
    output logic [CNT_WIDTH-1:0] rd_value,
    output logic [WIDTH-1:0]     cap_flag,
    output logic [WIDTH-1:0]     cap_ovf,
    output logic                 irq
);

    logic [WIDTH-1:0]     sel_hit_s;
    logic [WIDTH-1:0]     clr_s;
    logic [WIDTH-1:0]     flag_next_s;
    logic [CNT_WIDTH-1:0] cap_value_s [WIDTH];
    logic                 irq_q;

    // Decode rd_sel and mux the selected capture register; out-of-range selects hit nothing.
    always_comb begin
        sel_hit_s = {WIDTH{1'b0}};
        rd_value  = {CNT_WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (rd_sel == SEL_WIDTH'(i)) begin
                sel_hit_s[i] = 1'b1;
                rd_value     = cap_value_s[i];
            end else begin
                sel_hit_s[i] = 1'b0;
            end
        end
    end

    assign clr_s = sel_hit_s & {WIDTH{rd_en}};

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        timer_capture_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk         (clk),
            .n_rst       (n_rst),
            .edge_i      (edge_detected[g]),
            .clr_i       (clr_s[g]),
            .tc_value_i  (tc_value),
            .cap_value_o (cap_value_s[g]),
            .flag_o      (cap_flag[g]),
            .ovf_o       (cap_ovf[g]),
            .flag_next_o (flag_next_s[g])
        );
    end

    // Interrupt follows next-cycle flags so it rises and falls together with cap_flag.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(flag_next_s & cap_ie);
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_input_capture.sv
// Scoreboard bench for timer_input_capture: directed stimulus queues expected outputs per cycle.
module tb_timer_input_capture;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  edge_detected;
    logic [31:0] tc_value;
    logic [7:0]  cap_ie;
    logic        rd_en;
    logic [2:0]  rd_sel;
    logic [31:0] rd_value;
    logic [7:0]  cap_flag;
    logic [7:0]  cap_ovf;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [7:0]  flag;
        logic [7:0]  ovf;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];

    timer_input_capture dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .edge_detected (edge_detected),
        .tc_value      (tc_value),
        .cap_ie        (cap_ie),
        .rd_en         (rd_en),
        .rd_sel        (rd_sel),
        .rd_value      (rd_value),
        .cap_flag      (cap_flag),
        .cap_ovf       (cap_ovf),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: mid-cycle, compare every expectation due this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: missed check slot, cycle %0d required %0d", e.name, cyc, e.cyc);
            end else begin
                checks++;
                if (cap_flag !== e.flag) begin
                    failures++;
                    $display("FAIL %s.cap_flag: got %h expected %h", e.name, cap_flag, e.flag);
                end
                checks++;
                if (cap_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL %s.cap_ovf: got %h expected %h", e.name, cap_ovf, e.ovf);
                end
                checks++;
                if (rd_value !== e.rd) begin
                    failures++;
                    $display("FAIL %s.rd_value: got %h expected %h", e.name, rd_value, e.rd);
                end
                checks++;
                if (irq !== e.irq) begin
                    failures++;
                    $display("FAIL %s.irq: got %b expected %b", e.name, irq, e.irq);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [7:0] flag, input logic [7:0] ovf,
                              input logic [31:0] rd, input logic irq_e);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.flag = flag;
        e.ovf  = ovf;
        e.rd   = rd;
        e.irq  = irq_e;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ovf_val;
        logic [31:0] ch5_val;
`ifdef TIMER_CAPTURE_HOLD_FIRST_EN
        ovf_val = 32'd10;
        ch5_val = 32'd55;
`else
        ovf_val = 32'd20;
        ch5_val = 32'd66;
`endif
        n_rst = 1'b0; edge_detected = 8'hFF; tc_value = 32'h0000_00AA;
        cap_ie = 8'h00; rd_en = 1'b0; rd_sel = 3'd0;

        // Reset held two cycles with edges active.
        step(); step();
        n_rst = 1'b1; edge_detected = 8'h00;
        expect_now("reset", 8'h00, 8'h00, 32'h0, 1'b0);

        // Single capture on channel 2 with interrupt enabled, then read-clear.
        step();
        edge_detected = 8'h04; tc_value = 32'h0000_1234; cap_ie = 8'h04; rd_sel = 3'd2;
        step();
        edge_detected = 8'h00; rd_en = 1'b1;
        expect_now("cap2", 8'h04, 8'h00, 32'h0000_1234, 1'b1);
        step();
        rd_en = 1'b0;
        expect_now("clr2", 8'h00, 8'h00, 32'h0000_1234, 1'b0);

        // Overrun on channel 0.
        step();
        cap_ie = 8'h00; rd_sel = 3'd0; edge_detected = 8'h01; tc_value = 32'd10;
        step();
        tc_value = 32'd20;
        expect_now("ovf0_first", 8'h01, 8'h00, 32'd10, 1'b0);
        step();
        edge_detected = 8'h00;
        expect_now("ovf0", 8'h01, 8'h01, ovf_val, 1'b0);
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        expect_now("clr0", 8'h00, 8'h00, ovf_val, 1'b0);

        // Channel 5: overrun, then simultaneous read and edge.
        step();
        cap_ie = 8'h20; rd_sel = 3'd5; edge_detected = 8'h20; tc_value = 32'd55;
        step();
        tc_value = 32'd66;
        expect_now("ch5_first", 8'h20, 8'h00, 32'd55, 1'b1);
        step();
        edge_detected = 8'h00;
        expect_now("ch5_ovf", 8'h20, 8'h20, ch5_val, 1'b1);
        step();
        rd_en = 1'b1; edge_detected = 8'h20; tc_value = 32'd77;
        expect_now("ch5_rd_edge", 8'h20, 8'h20, ch5_val, 1'b1);
        step();
        rd_en = 1'b0; edge_detected = 8'h00;
        expect_now("ch5_after", 8'h20, 8'h00, 32'd77, 1'b1);

        // Multi-channel capture at count wrap value.
        step();
        edge_detected = 8'hA5; tc_value = 32'hFFFF_FFFF; rd_sel = 3'd7;
        step();
        edge_detected = 8'h00;
        expect_now("multi_ch7", 8'hA5, 8'h20, 32'hFFFF_FFFF, 1'b1);
        step();
        rd_sel = 3'd0;
        expect_now("multi_ch0", 8'hA5, 8'h20, 32'hFFFF_FFFF, 1'b1);
        step();
        rd_sel = 3'd1;
        expect_now("multi_ch1", 8'hA5, 8'h20, 32'h0, 1'b1);
        step();
        rd_sel = 3'd2;
        expect_now("multi_ch2", 8'hA5, 8'h20, 32'hFFFF_FFFF, 1'b1);

        // Reset just after a capture; a capture during reset is discarded.
        step();
        edge_detected = 8'h02; tc_value = 32'd5; rd_sel = 3'd1;
        step();
        edge_detected = 8'h08; n_rst = 1'b0;
        expect_now("pre_reset", 8'hA7, 8'h20, 32'd5, 1'b1);
        step();
        edge_detected = 8'h00; n_rst = 1'b1; rd_sel = 3'd3;
        expect_now("post_reset", 8'h00, 8'h00, 32'h0, 1'b0);
        step();
        rd_sel = 3'd5;
        expect_now("post_reset_ch5", 8'h00, 8'h00, 32'h0, 1'b0);

        step(); step();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
